// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch definitions: the program window, the sequential step, the
// fetch-state encoding and the window/alignment legality helper.
package pc_fetch_unit_pkg;

    // The address decoder also uses this window, so both blocks agree on it.
    localparam logic [31:0] PROG_LOWER = 32'h0000_18C0;
    localparam logic [31:0] PROG_UPPER = 32'h0000_1CBF;
    localparam logic [31:0] PC_STEP    = 32'd4;

    // Fetch FSM encoding, kept as plain constants for compatibility with older blocks.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_RUN   = 1'b0;
    localparam fetch_state_t ST_FAULT = 1'b1;

    // A PC is fetchable when it lies inside the window and is word aligned.
    function automatic logic pc_is_legal(input logic [31:0] pc);
        return (pc >= PROG_LOWER) && (pc <= PROG_UPPER) && (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: jump > branch > stall > sequential,
// plus a legality flag for the chosen candidate.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] address,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] npc,
    output logic        redirect,
    output logic        hold_pc,
    output logic        legal
);

    // Priority mux choosing the candidate next PC.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        npc      = address + PC_STEP;
        redirect = 1'b0;
        hold_pc  = 1'b0;
        if (jump) begin
            npc      = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            npc      = branch_target;
            redirect = 1'b1;
        end else if (stall) begin
            npc     = address;
            hold_pc = 1'b1;
        end
    end

    assign legal = pc_is_legal(npc);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs returned instructions with their
// PC, buffers the instruction across stalls and latches a sticky fault when the
// next PC leaves the program window or is misaligned.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] instr_in,
    output logic [31:0] address,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    fetch_state_t state;
    logic [31:0]  hold_buf;
    logic         use_hold;
    logic [31:0]  npc;
    logic         redirect;
    logic         hold_pc;
    logic         legal;

    pc_next_sel u_next_sel (
        .address       (address),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .npc           (npc),
        .redirect      (redirect),
        .hold_pc       (hold_pc),
        .legal         (legal)
    );

    // PC, output pair, hold buffer and fault FSM update.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= ST_RUN;
            address    <= PROG_LOWER;
            pc_out     <= PROG_LOWER;
            valid      <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= '0;
            hold_buf   <= '0;
            use_hold   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hold_pc) begin
                        // Stall: keep the pair, capture the live instruction once.
                        if (!use_hold) begin
                            hold_buf <= instr_in;
                            use_hold <= 1'b1;
                        end
                    end else if (!legal) begin
                        // Address and pc_out keep their values for post-mortem.
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_addr <= npc;
                        valid      <= 1'b0;
                        use_hold   <= 1'b0;
                    end else if (redirect) begin
                        // The word fetched from the old address is squashed.
                        address  <= npc;
                        valid    <= 1'b0;
                        use_hold <= 1'b0;
                    end else begin
                        pc_out   <= address;
                        valid    <= 1'b1;
                        address  <= npc;
                        use_hold <= 1'b0;
                    end
                end
                default: begin
                    // Only reset leaves the fault state.
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // The memory keeps re-reading the held address, so instr_in is only stale
    // while stalled; the buffered copy covers that window.
    assign instr_out = valid ? (use_hold ? hold_buf : instr_in) : 32'h0;

endmodule
